lsu_rmw: RTL and testbench
==========================

# lsu_rmw

Load/store unit between the RV32 core's memory-stage control and the byte-organised data memory. The data memory only performs full 32-bit little-endian accesses with one-cycle registered read data. This block converts RV32I LB/LH/LW/LBU/LHU/SB/SH/SW requests into aligned word accesses:
- sign/zero extraction for loads;
- read-modify-write for byte and halfword stores;
- alignment and range checking.

The core stalls on `req_ready`/`rsp_valid`.

## Interface
- `MEM_BYTES`, default 1024: memory size in bytes. Aligned word address must be < `MEM_BYTES`.
- `clk` in 1: single clock, all state on rising edge.
- `rst_n` in 1: asynchronous active-low reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: high only in IDLE; a request is accepted on an edge where `req_valid && req_ready`.
- `req_we` in 1: 1 = store, 0 = load.
- `req_funct3` in 3: RV32I funct3.
  - Loads: 0 LB, 1 LH, 2 LW, 4 LBU, 5 LHU.
  - Stores: 0 SB, 1 SH, 2 SW.
- `req_addr` in 32: byte address.
- `req_wdata` in 32: store data. Low byte or low half is used for SB/SH.
- `rsp_valid` out 1: one-cycle completion pulse.
- `rsp_rdata` out 32: extended load result. 0 for stores and errors.
- `rsp_err` out 1: misaligned, out-of-range or illegal funct3. Valid with `rsp_valid`.
- `mem_addr` out 32: word-aligned address `{addr[31:2],2'b00}` to memory.
- `mem_wdata` out 32: full word to write.
- `mem_rw` out 1: 1 = write. High only in the WR state.
- `mem_rdata` in 32: memory read data, registered by memory one edge after the address is presented with `mem_rw=0`.

## Operation
- States: IDLE, RD, CAP, WR, RESP.
- On accept, latch `we`, `funct3`, `addr`, `wdata`, and compute the error.
- Error conditions:
  - illegal funct3 for the direction;
  - halfword with `addr[0]=1`;
  - word with `addr[1:0]≠0`;
  - `{addr[31:2],2'b00}` ≥ `MEM_BYTES`.
- State transitions from IDLE on accept:
  - Error → RESP (no memory write ever issued).
  - SW → WR.
  - All loads, SB, SH → RD.
- RD:
  - `mem_addr` = aligned address, `mem_rw=0`.
  - → CAP.
- CAP: `mem_rdata` holds the word.
  - Load: register the extracted result, → RESP.
    - Byte lane is `addr[1:0]` (bits `8*lane+7:8*lane`).
    - Half lane is `addr[1]` (bits 15:0 or 31:16).
    - LB/LH sign-extend; LBU/LHU zero-extend; LW passes through.
  - SB/SH: register the merged word (addressed lane replaced by `wdata[7:0]`/`[15:0]`, other bytes preserved), → WR.
- WR:
  - `mem_rw=1`, `mem_wdata` = merged word, or `req_wdata` for SW.
  - → RESP.
- RESP:
  - `rsp_valid=1`; `rsp_rdata`/`rsp_err` valid.
  - → IDLE.
- `mem_addr`/`mem_wdata` hold their last values outside RD/WR.
- `mem_rw` is 0 in every state but WR.
- Requests are never accepted outside IDLE. `req_*` inputs are ignored after accept.
- Back-to-back: RESP → IDLE, so a new request is accepted on the edge after the RESP cycle.
- Reset (asynchronous, any state):
  - State → IDLE.
  - `rsp_valid`, `rsp_err`, `mem_rw`: 0.
  - `rsp_rdata`, `mem_addr`, `mem_wdata`: 0.
  - `req_ready`: 1 (state is IDLE).
- Reset mid-operation abandons the request with no response. A store reset before its WR edge performs no write.

## Timing
Cycle 0 is the accept cycle (IDLE, `req_valid=1`).
- Load: RD in cycle 1, CAP in cycle 2, `rsp_valid` in cycle 3. Latency 3.
- SB/SH: RD 1, CAP 2, WR 3 (write on the edge ending cycle 3), `rsp_valid` in cycle 4. Latency 4.
- SW: WR 1, `rsp_valid` in cycle 2. Latency 2.
- Error: `rsp_valid` + `rsp_err` in cycle 1. Latency 1.
- Next accept is possible in the cycle after `rsp_valid`.
- Throughput is 1 request per latency+1 cycles.
- Outputs `req_ready`, `mem_rw`, `rsp_valid` are decoded from registered state only (no input-to-output combinational path).

## Test plan
- **Word round-trip:** SW addr 0x10 data 0xDEADBEEF, then LW 0x10.
  - SW: `mem_rw` high exactly cycle 1, `rsp_valid` cycle 2.
  - LW: `rsp_rdata`=0xDEADBEEF, `rsp_valid` cycle 3, `rsp_err`=0.
- **Byte merge:** after the above, SB addr 0x12 data 0x000000A5; LW 0x10.
  - SB: `mem_rw` high cycle 3 only, `mem_wdata`=0xDEA5BEEF.
  - LW returns 0xDEA5BEEF.
- **Extension:** memory 0x80 = 0x8001FF7F.
  - LB 0x80→0x0000007F; LB 0x81→0xFFFFFFFF; LBU 0x81→0x000000FF.
  - LH 0x82→0xFFFF8001; LHU 0x82→0x00008001.
- **Errors:** LW 0x11, SH 0x13, SW 0x400 (`MEM_BYTES`=1024), load funct3=3.
  - Each gives `rsp_err=1` in cycle 1, `rsp_rdata`=0.
  - `mem_rw` never asserted; memory contents unchanged.
- **Handshake:** `req_valid` held high continuously with changing requests.
  - `req_ready` low in RD/CAP/WR/RESP.
  - Only requests present in IDLE cycles are executed, each exactly once.
- **Reset mid-op:** SH 0x20 with `rst_n` pulsed low during CAP.
  - Outputs immediately at reset values.
  - No write to 0x20; no `rsp_valid`.
  - `req_ready`=1 after release.

Source files
------------

// File: rtl/lsu_rmw.sv
// lsu_rmw: RV32I load/store unit in front of a word-only data memory.
// Byte and halfword stores are done as read-modify-write of the containing
// word. Loads extract and extend the addressed lane from a full-word read.
//
//   state  | meaning
//   -------+--------------------------------------------------------------
//   IDLE   | ready for a request; the only state that accepts one
//   RD     | aligned address presented with mem_rw=0
//   CAP    | mem_rdata holds the word; extract the load value or merge the store
//   WR     | mem_rw=1, full merged (or SW) word driven to memory
//   RESP   | rsp_valid pulse with rsp_rdata / rsp_err
module lsu_rmw #(
  parameter int unsigned MEM_BYTES = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_rw,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_CAP,
    S_WR,
    S_RESP
  } state_t;

  state_t state, state_nxt;

  // Request fields kept after accept; only the bits used later are stored.
  logic        we_q;
  logic [2:0]  f3_q;
  logic [1:0]  lane_q;
  logic [15:0] wdata_q;
  logic        err_q;
  logic [31:0] res_q;
  logic [31:0] mem_addr_q;
  logic [31:0] mem_wdata_q;

  logic        accept;
  logic        f3_legal;
  logic        misalign;
  logic        out_of_range;
  logic        req_err;
  logic        req_is_sw;
  logic [31:0] addr_aligned;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_val;
  logic [31:0] merge_val;

  assign accept       = req_valid && (state == S_IDLE);
  assign addr_aligned = {req_addr[31:2], 2'b00};
  assign out_of_range = (addr_aligned >= 32'(MEM_BYTES));
  assign req_is_sw    = req_we && (req_funct3 == 3'd2);
  assign req_err      = !f3_legal || misalign || out_of_range;

  // Legal funct3 depends on direction; misalignment by access size.
  always_comb begin
    f3_legal = 1'b0;
    misalign = 1'b0;
    if (req_we) begin
      f3_legal = (req_funct3 == 3'd0) || (req_funct3 == 3'd1) || (req_funct3 == 3'd2);
    end else begin
      case (req_funct3)
        3'd0, 3'd1, 3'd2, 3'd4, 3'd5: f3_legal = 1'b1;
        default:                      f3_legal = 1'b0;
      endcase
    end
    if (req_funct3[1:0] == 2'b01) begin
      misalign = req_addr[0];
    end else if (req_funct3[1:0] == 2'b10) begin
      misalign = (req_addr[1:0] != 2'b00);
    end
  end

  // Lane selection and sign/zero extension of the captured word.
  always_comb begin
    byte_sel = mem_rdata[7:0];
    case (lane_q)
      2'd0:    byte_sel = mem_rdata[7:0];
      2'd1:    byte_sel = mem_rdata[15:8];
      2'd2:    byte_sel = mem_rdata[23:16];
      default: byte_sel = mem_rdata[31:24];
    endcase
    half_sel = lane_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (f3_q)
      3'd0:    load_val = {{24{byte_sel[7]}}, byte_sel};
      3'd1:    load_val = {{16{half_sel[15]}}, half_sel};
      3'd4:    load_val = {24'h0, byte_sel};
      3'd5:    load_val = {16'h0, half_sel};
      default: load_val = mem_rdata;
    endcase
  end

  // Replace the addressed byte/half of the captured word, keep the rest.
  always_comb begin
    merge_val = mem_rdata;
    if (f3_q[1:0] == 2'b00) begin
      case (lane_q)
        2'd0:    merge_val[7:0]   = wdata_q[7:0];
        2'd1:    merge_val[15:8]  = wdata_q[7:0];
        2'd2:    merge_val[23:16] = wdata_q[7:0];
        default: merge_val[31:24] = wdata_q[7:0];
      endcase
    end else if (lane_q[1]) begin
      merge_val[31:16] = wdata_q;
    end else begin
      merge_val[15:0] = wdata_q;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and state-decoded handshake/strobe outputs.
  always_comb begin
    state_nxt = state;
    req_ready = 1'b0;
    mem_rw    = 1'b0;
    rsp_valid = 1'b0;
    case (state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (req_err)        state_nxt = S_RESP;
          else if (req_is_sw) state_nxt = S_WR;
          else                state_nxt = S_RD;
        end
      end
      S_RD:  state_nxt = S_CAP;
      S_CAP: state_nxt = we_q ? S_WR : S_RESP;
      S_WR: begin
        mem_rw    = 1'b1;
        state_nxt = S_RESP;
      end
      S_RESP: begin
        rsp_valid = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Request latch, memory address/data and load result registers.
  // Errored requests leave mem_addr/mem_wdata untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q        <= 1'b0;
      f3_q        <= 3'd0;
      lane_q      <= 2'd0;
      wdata_q     <= 16'h0;
      err_q       <= 1'b0;
      res_q       <= 32'h0;
      mem_addr_q  <= 32'h0;
      mem_wdata_q <= 32'h0;
    end else if (accept) begin
      we_q    <= req_we;
      f3_q    <= req_funct3;
      lane_q  <= req_addr[1:0];
      wdata_q <= req_wdata[15:0];
      err_q   <= req_err;
      res_q   <= 32'h0;
      if (!req_err) begin
        mem_addr_q <= addr_aligned;
        if (req_is_sw) mem_wdata_q <= req_wdata;
      end
    end else if (state == S_CAP) begin
      if (we_q) mem_wdata_q <= merge_val;
      else      res_q       <= load_val;
    end
  end

  assign rsp_rdata = res_q;
  assign rsp_err   = (state == S_RESP) && err_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_lsu_rmw.sv
// Directed bench for lsu_rmw with a 1 KiB word memory model.
module tb_lsu_rmw;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_rw;
  logic [31:0] mem_rdata;

  int passed = 0;
  int total  = 0;

  logic [31:0] mem [0:255] = '{default: 32'h0};
  logic [7:0]  midx;
  logic        m_in_range;

  lsu_rmw #(.MEM_BYTES(1024)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rw     (mem_rw),
    .mem_rdata  (mem_rdata)
  );

  always #5 clk = ~clk;

  assign midx       = mem_addr[9:2];
  assign m_in_range = (mem_addr < 32'd1024);

  // Word memory: write when mem_rw, registered read data one edge later.
  always @(posedge clk) begin
    if (m_in_range) begin
      if (mem_rw) mem[midx] <= mem_wdata;
      mem_rdata <= mem[midx];
    end else begin
      mem_rdata <= 32'h0;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Issue one request at an IDLE negedge; cycle 0 is the accept cycle.
  // exp_wr_cyc <= 0 means no memory write may occur.
  task automatic do_req(input string tag, input logic we, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd,
                        input int exp_lat, input logic [31:0] exp_rd,
                        input logic exp_err, input int exp_wr_cyc,
                        input logic [31:0] exp_wd);
    int lat, wr_cyc, wr_cnt;
    logic [31:0] wd_seen, rd_seen;
    logic err_seen;
    lat = -1; wr_cyc = -1; wr_cnt = 0;
    wd_seen = 32'h0; rd_seen = 32'hX; err_seen = 1'bX;
    @(negedge clk);
    chk({tag, "_ready"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
    @(posedge clk);
    #1;
    req_valid  = 1'b0;
    req_we     = ~we;
    req_funct3 = 3'd3;
    req_addr   = 32'hFFFF_FFFF;
    req_wdata  = $urandom;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (mem_rw) begin
        wr_cnt++;
        wr_cyc  = c;
        wd_seen = mem_wdata;
      end
      if (rsp_valid) begin
        lat      = c;
        rd_seen  = rsp_rdata;
        err_seen = rsp_err;
        break;
      end
    end
    chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    chk({tag, "_rdata"}, rd_seen, exp_rd);
    chk({tag, "_err"}, 32'(err_seen), 32'(exp_err));
    chk({tag, "_wrcnt"}, 32'(wr_cnt), (exp_wr_cyc > 0) ? 32'd1 : 32'd0);
    if (exp_wr_cyc > 0) begin
      chk({tag, "_wrcyc"}, 32'(wr_cyc), 32'(exp_wr_cyc));
      chk({tag, "_wdata"}, wd_seen, exp_wd);
    end
  endtask

  initial begin
    int hs_wr;
    int post_rsp, post_wr;
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0;
    req_addr = 32'h0; req_wdata = 32'h0;
    #12;
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_mem_rw", 32'(mem_rw), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_rsp_rdata", rsp_rdata, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Word round trip and byte merge
    do_req("sw10", 1, 3'd2, 32'h10, 32'hDEADBEEF, 2, 32'h0, 0, 1, 32'hDEADBEEF);
    do_req("lw10", 0, 3'd2, 32'h10, 32'h0, 3, 32'hDEADBEEF, 0, -1, 32'h0);
    do_req("sb12", 1, 3'd0, 32'h12, 32'h000000A5, 4, 32'h0, 0, 3, 32'hDEA5BEEF);
    do_req("lw10b", 0, 3'd2, 32'h10, 32'h0, 3, 32'hDEA5BEEF, 0, -1, 32'h0);

    // Extension
    do_req("sw80", 1, 3'd2, 32'h80, 32'h8001FF7F, 2, 32'h0, 0, 1, 32'h8001FF7F);
    do_req("lb80", 0, 3'd0, 32'h80, 32'h0, 3, 32'h0000007F, 0, -1, 32'h0);
    do_req("lb81", 0, 3'd0, 32'h81, 32'h0, 3, 32'hFFFFFFFF, 0, -1, 32'h0);
    do_req("lbu81", 0, 3'd4, 32'h81, 32'h0, 3, 32'h000000FF, 0, -1, 32'h0);
    do_req("lb83", 0, 3'd0, 32'h83, 32'h0, 3, 32'hFFFFFF80, 0, -1, 32'h0);
    do_req("lh80", 0, 3'd1, 32'h80, 32'h0, 3, 32'hFFFFFF7F, 0, -1, 32'h0);
    do_req("lh82", 0, 3'd1, 32'h82, 32'h0, 3, 32'hFFFF8001, 0, -1, 32'h0);
    do_req("lhu82", 0, 3'd5, 32'h82, 32'h0, 3, 32'h00008001, 0, -1, 32'h0);
    do_req("sh82", 1, 3'd1, 32'h82, 32'hABCD1234, 4, 32'h0, 0, 3, 32'h1234FF7F);
    do_req("lw80", 0, 3'd2, 32'h80, 32'h0, 3, 32'h1234FF7F, 0, -1, 32'h0);
    do_req("lw3fc", 0, 3'd2, 32'h3FC, 32'h0, 3, 32'h0, 0, -1, 32'h0);

    // Errors
    do_req("e_lw11", 0, 3'd2, 32'h11, 32'h0, 1, 32'h0, 1, -1, 32'h0);
    do_req("e_sh13", 1, 3'd1, 32'h13, 32'h5555, 1, 32'h0, 1, -1, 32'h0);
    do_req("e_sw400", 1, 3'd2, 32'h400, 32'h12345678, 1, 32'h0, 1, -1, 32'h0);
    do_req("e_ld_f3", 0, 3'd3, 32'h10, 32'h0, 1, 32'h0, 1, -1, 32'h0);
    do_req("e_st_f4", 1, 3'd4, 32'h10, 32'h11111111, 1, 32'h0, 1, -1, 32'h0);
    chk("err_mem10", mem[4], 32'hDEA5BEEF);

    // Handshake: req_valid held high, a new SW every cycle
    @(negedge clk);
    hs_wr = 0;
    for (int k = 0; k < 12; k++) begin
      req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'd2;
      req_addr  = 32'h40 + 32'(4 * k);
      req_wdata = 32'h1000_0000 + 32'(k);
      chk("hs_ready", 32'(req_ready), 32'((k % 3) == 0));
      if (mem_rw) hs_wr++;
      @(negedge clk);
    end
    req_valid = 1'b0;
    chk("hs_wrcnt", 32'(hs_wr), 32'd4);
    for (int k = 0; k < 12; k++) begin
      chk("hs_mem", mem[16 + k], ((k % 3) == 0) ? 32'h1000_0000 + 32'(k) : 32'h0);
    end

    // Reset in the middle of an SH
    do_req("sw20", 1, 3'd2, 32'h20, 32'hCAFEF00D, 2, 32'h0, 0, 1, 32'hCAFEF00D);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'd1; req_addr = 32'h20; req_wdata = 32'h1234;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mr_ready", 32'(req_ready), 32'd1);
    chk("mr_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("mr_mem_rw", 32'(mem_rw), 32'd0);
    chk("mr_mem_addr", mem_addr, 32'h0);
    chk("mr_mem_wdata", mem_wdata, 32'h0);
    chk("mr_rsp_rdata", rsp_rdata, 32'h0);
    chk("mr_rsp_err", 32'(rsp_err), 32'd0);
    #2;
    rst_n = 1'b1;
    post_rsp = 0; post_wr = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (rsp_valid) post_rsp++;
      if (mem_rw) post_wr++;
    end
    chk("mr_no_rsp", 32'(post_rsp), 32'd0);
    chk("mr_no_wr", 32'(post_wr), 32'd0);
    chk("mr_mem20", mem[8], 32'hCAFEF00D);
    chk("mr_ready_after", 32'(req_ready), 32'd1);
    do_req("lw20", 0, 3'd2, 32'h20, 32'h0, 3, 32'hCAFEF00D, 0, -1, 32'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
